pow_target_checker: RTL
=======================

// Module: pow_target_checker
// PURPOSE
//   Streaming multi-word magnitude comparator for proof-of-work checking. Accepts a
//   NUM_WORDS x WORD_W hash, most-significant word first, over a valid/ready handshake.
//   Compares the hash against a locally stored difficulty target and reports
//   less/equal/greater. A hash strictly less than the target is a valid block
//   solution and is counted. Sits downstream of the hash core, upstream of nonce control.
// PARAMETERS
//   WORD_W     32  width of one hash/target word
//   NUM_WORDS  8   words per hash (256-bit default)
//   CNT_W      16  width of the saturating solution counter
// PORTS
//   clk           in   1              rising-edge clock
//   rst           in   1              asynchronous active-high reset
//   tgt_we        in   1              target word write strobe
//   tgt_addr      in   clog2(NUM_WORDS) target word index, 0 = most significant
//   tgt_wdata     in   WORD_W         target word data
//   busy          out  1              high while a hash is in progress or a result is held
//   in_valid      in   1              hash word valid
//   in_ready      out  1              checker can accept a hash word
//   in_data       in   WORD_W         hash word, MSW first
//   res_valid     out  1              result valid; held until res_ready
//   res_ready     in   1              result consumer ready
//   res_less      out  1              hash <  target
//   res_equal     out  1              hash == target
//   res_greater   out  1              hash >  target
//   sol_count     out  CNT_W          number of results with res_less=1, saturating
// BEHAVIOUR
//   - Reset (async, immediate): state=IDLE, word count=0, relation=EQUAL.
//     Target array is cleared to 0. in_ready=1, res_valid=0, res_* = 0, sol_count=0, busy=0.
//   - FSM: IDLE -> RUN on the first accepted word. RUN -> DONE when word NUM_WORDS-1
//     is accepted. DONE -> IDLE on res_valid && res_ready.
//   - A word is accepted when in_valid && in_ready. in_ready = (state != DONE).
//   - Word compare uses unsigned WORD_W magnitude. The relation latch starts at EQUAL
//     for each hash. The first unequal word sets LESS or GREATER. Later words do not
//     change a latched LESS/GREATER.
//   - Word k of the hash is compared with target[k]. k is the accepted-word counter,
//     0..NUM_WORDS-1. The counter wraps to 0 after the last word.
//   - Latency: res_valid rises on the cycle after the last word is accepted.
//     Exactly one of res_less/res_equal/res_greater is 1 while res_valid=1.
//     All three are 0 while res_valid=0.
//   - sol_count increments by 1 on the cycle res_valid rises with res_less=1.
//     It saturates at 2^CNT_W-1 and does not wrap.
//   - Back-to-back operation: if res_ready=1 when res_valid=1, the result is consumed
//     that cycle. in_ready is 1 on the next cycle. No hash word is accepted in the
//     same cycle as a consumed result.
//   - busy = (state != IDLE).
//   - Target writes: accepted only when busy=0. Writes while busy=1 are ignored and
//     the target is unchanged. A write and a first hash word in the same cycle
//     (busy=0): the write lands, and word 0 compares against the pre-write target.
//   - in_valid is ignored in DONE. in_data is don't-care when in_valid=0.
//     Gaps between words are allowed without limit.
//   - NUM_WORDS=1: IDLE -> DONE directly on the single accepted word.
//   - Reset asserted mid-hash or while holding a result aborts everything
//     to the reset values above.
// TESTING
//   1 Target = 0x00000000_FFFFFFFF... (word0=0, others all-ones); hash word0=0,
//     word1=0xFFFFFFFE -> res_less=1 one cycle after word 7; sol_count=1.
//   2 Hash identical to target -> res_equal=1; sol_count unchanged.
//   3 Hash word0=1 > target word0=0, remaining words all 0 -> res_greater=1.
//     A later smaller word does not flip the result.
//   4 Hold res_ready=0 for 5 cycles after res_valid -> res_* stable, in_ready=0,
//     extra in_valid words ignored. Then res_ready=1 -> next hash starts cleanly.
//   5 tgt_we pulsed while busy=1 -> readback via next compare shows the old target.
//     Async rst pulsed after word 3 -> all outputs at reset values immediately,
//     and the next hash is compared from word 0.
//   6 Drive 2^CNT_W+2 less-than results (CNT_W=4 build) -> sol_count stops at 15.

Source files
------------

// File: rtl/pow_target_checker.sv
// rtl/pow_target_checker.sv - streaming multi-word hash vs difficulty-target magnitude comparator
// Hash words arrive MSW first; the first unequal word decides the relation for the whole hash.
module pow_target_checker #(
  parameter int WORD_W    = 32,
  parameter int NUM_WORDS = 8,
  parameter int CNT_W     = 16,
  localparam int AW       = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tgt_we,
  input  logic [AW-1:0]     tgt_addr,
  input  logic [WORD_W-1:0] tgt_wdata,
  output logic              busy,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              res_less,
  output logic              res_equal,
  output logic              res_greater,
  output logic [CNT_W-1:0]  sol_count
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  typedef enum logic [1:0] {REL_EQ, REL_LT, REL_GT} rel_t;

  state_t            state, state_nx;
  rel_t              rel, rel_nx, word_rel;
  logic [AW-1:0]     cnt;
  logic [WORD_W-1:0] target [NUM_WORDS];
  logic              accept, last_word, consume, tgt_hit;

  assign accept    = in_valid && in_ready;
  assign consume   = res_valid && res_ready;
  assign last_word = (cnt == AW'(NUM_WORDS - 1));
  assign tgt_hit   = tgt_we && (state == S_IDLE) && (32'(tgt_addr) < NUM_WORDS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (accept) state_nx = last_word ? S_DONE : S_RUN;
      S_RUN:   if (accept && last_word) state_nx = S_DONE;
      S_DONE:  if (consume) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready    = (state != S_DONE);
    busy        = (state != S_IDLE);
    res_valid   = (state == S_DONE);
    res_less    = (state == S_DONE) && (rel == REL_LT);
    res_equal   = (state == S_DONE) && (rel == REL_EQ);
    res_greater = (state == S_DONE) && (rel == REL_GT);
  end

  always_comb begin
    word_rel = REL_EQ;
    if (in_data < target[cnt])      word_rel = REL_LT;
    else if (in_data > target[cnt]) word_rel = REL_GT;
  end

  // Only an undecided (EQUAL) relation may be overwritten; it restarts when the result is taken.
  always_comb begin
    rel_nx = rel;
    if (consume)                      rel_nx = REL_EQ;
    else if (accept && rel == REL_EQ) rel_nx = word_rel;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      rel       <= REL_EQ;
      sol_count <= '0;
    end else begin
      rel <= rel_nx;
      if (accept) cnt <= last_word ? '0 : cnt + AW'(1);
      if (accept && last_word && rel_nx == REL_LT && sol_count != {CNT_W{1'b1}})
        sol_count <= sol_count + CNT_W'(1);
    end
  end

  // Word 0 reads the target before a same-cycle write lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_WORDS; i++) target[i] <= '0;
    end else if (tgt_hit) begin
      target[tgt_addr] <= tgt_wdata;
    end
  end

endmodule
